// File: rtl/mem_stage_pkg.sv
// Shared constants and bus layouts for the memory-access stage.
// The packed structs mirror the execute-to-memory and memory-to-writeback bus bit layouts.
package mem_stage_pkg;

  localparam int ES_TO_MS_BUS_WD = 153;
  localparam int MS_TO_WS_BUS_WD = 117;
  localparam logic [4:0] NO_EX   = 5'h1f;

  typedef enum logic [2:0] {
    LOAD_OP_LW   = 3'd0,
    LOAD_OP_LB   = 3'd1,
    LOAD_OP_LBU  = 3'd2,
    LOAD_OP_LH   = 3'd3,
    LOAD_OP_LHU  = 3'd4,
    LOAD_OP_LWL  = 3'd5,
    LOAD_OP_LWR  = 3'd6,
    LOAD_OP_NONE = 3'd7
  } load_op_e;

  typedef struct packed {
    logic [4:0]  rd;
    logic        mfc0;
    logic        mtc0;
    logic        pc_error;
    logic [31:0] badvaddr;
    logic [4:0]  ex_code;
    logic        eret;
    logic        slot;
    logic        gr_we;
    logic [4:0]  dest;
    logic [31:0] result;
    logic [31:0] pc;
  } ms_to_ws_t;

  typedef struct packed {
    logic [31:0] rt_value;
    load_op_e    load_op;
    logic        data_req;
    ms_to_ws_t   payload;
  } es_to_ms_t;

endpackage

// File: rtl/mem_stage_load_align.sv
// Combinational load-data extraction: byte/half selection with sign/zero extension, and
// lwl/lwr merges with the old rt value. Non-load ops pass the ALU result through.
module mem_stage_load_align
  import mem_stage_pkg::*;
(
  input  load_op_e    i_load_op,
  input  logic [31:0] i_result,
  input  logic [31:0] i_data,
  input  logic [31:0] i_rt,
  output logic [31:0] o_result
);

  logic [1:0]  w_addr;
  logic [7:0]  w_byte;
  logic [15:0] w_half;

  assign w_addr = i_result[1:0];
  assign w_half = w_addr[1] ? i_data[31:16] : i_data[15:0];

  always_comb begin
    case (w_addr)
      2'd0:    w_byte = i_data[7:0];
      2'd1:    w_byte = i_data[15:8];
      2'd2:    w_byte = i_data[23:16];
      default: w_byte = i_data[31:24];
    endcase
  end

  always_comb begin
    o_result = i_result;
    case (i_load_op)
      LOAD_OP_LW:  o_result = i_data;
      LOAD_OP_LB:  o_result = {{24{w_byte[7]}}, w_byte};
      LOAD_OP_LBU: o_result = {24'd0, w_byte};
      LOAD_OP_LH:  o_result = {{16{w_half[15]}}, w_half};
      LOAD_OP_LHU: o_result = {16'd0, w_half};
      LOAD_OP_LWL: begin
        case (w_addr)
          2'd0:    o_result = {i_data[7:0],  i_rt[23:0]};
          2'd1:    o_result = {i_data[15:0], i_rt[15:0]};
          2'd2:    o_result = {i_data[23:0], i_rt[7:0]};
          default: o_result = i_data;
        endcase
      end
      LOAD_OP_LWR: begin
        case (w_addr)
          2'd0:    o_result = i_data;
          2'd1:    o_result = {i_rt[31:24], i_data[31:8]};
          2'd2:    o_result = {i_rt[31:16], i_data[31:16]};
          default: o_result = {i_rt[31:8],  i_data[31:24]};
        endcase
      end
      default:     o_result = i_result;
    endcase
  end

endmodule

// File: rtl/mem_stage.sv
// MIPS memory-access stage: waits for the data-SRAM response of an issued load/store, aligns load
// data and hands the result to write-back over valid/allowin; holds while write-back stalls.
module mem_stage
  import mem_stage_pkg::*;
(
  input  logic                       clk,
  input  logic                       reset,
  output logic                       ms_allowin,
  input  logic                       es_to_ms_valid,
  input  logic [ES_TO_MS_BUS_WD-1:0] es_to_ms_bus,
  input  logic                       ws_allowin,
  output logic                       ms_to_ws_valid,
  output logic [MS_TO_WS_BUS_WD-1:0] ms_to_ws_bus,
  input  logic                       data_sram_data_ok,
  input  logic [31:0]                data_sram_rdata,
  input  logic                       ws_flush,
  output logic [4:0]                 MS_dest,
  output logic [31:0]                MS_dest_data,
  output logic                       MS_inst_mfc0,
  output logic                       ms_load_stall,
  output logic                       MS_EX
);

  logic        r_ms_valid;
  es_to_ms_t   r_bus;
  logic [31:0] r_rdata_buf;
  logic        r_rdata_buf_valid;
  logic [1:0]  r_cancel_cnt;

  logic        w_has_ex;
  logic        w_data_ok_live;
  logic        w_ready_go;
  logic        w_leave;
  logic        w_cancel_inc;
  logic        w_cancel_dec;
  logic [31:0] w_sel_data;
  logic [31:0] w_result;
  ms_to_ws_t   w_out;

  assign w_has_ex       = r_bus.payload.ex_code != NO_EX;
  // A response arriving while cancel_cnt>0 belongs to a flushed request.
  assign w_data_ok_live = data_sram_data_ok && (r_cancel_cnt == 2'd0);
  assign w_ready_go     = !r_bus.data_req || w_has_ex ||
                          ((r_cancel_cnt == 2'd0) && (data_sram_data_ok || r_rdata_buf_valid));
  assign ms_allowin     = !r_ms_valid || (w_ready_go && ws_allowin);
  assign w_leave        = r_ms_valid && w_ready_go && ws_allowin;
  assign w_cancel_inc   = ws_flush && r_ms_valid && r_bus.data_req &&
                          !r_rdata_buf_valid && !w_data_ok_live;
  assign w_cancel_dec   = data_sram_data_ok && (r_cancel_cnt != 2'd0);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_ms_valid               <= 1'b0;
      r_bus                    <= '0;
      r_bus.payload.ex_code    <= NO_EX;
      r_rdata_buf              <= 32'd0;
      r_rdata_buf_valid        <= 1'b0;
      r_cancel_cnt             <= 2'd0;
    end else begin
      if (ws_flush) begin
        r_ms_valid <= 1'b0;
      end else if (ms_allowin) begin
        r_ms_valid <= es_to_ms_valid;
      end

      if (es_to_ms_valid && ms_allowin) begin
        r_bus <= es_to_ms_t'(es_to_ms_bus);
      end

      // Keep the response when write-back cannot take it this cycle; the SRAM will not repeat it.
      if (ws_flush || w_leave) begin
        r_rdata_buf_valid <= 1'b0;
      end else if (r_ms_valid && w_data_ok_live && !ws_allowin) begin
        r_rdata_buf       <= data_sram_rdata;
        r_rdata_buf_valid <= 1'b1;
      end

      r_cancel_cnt <= r_cancel_cnt + {1'b0, w_cancel_inc} - {1'b0, w_cancel_dec};
    end
  end

  assign w_sel_data = r_rdata_buf_valid ? r_rdata_buf : data_sram_rdata;

  mem_stage_load_align u_load_align (
    .i_load_op (r_bus.load_op),
    .i_result  (r_bus.payload.result),
    .i_data    (w_sel_data),
    .i_rt      (r_bus.rt_value),
    .o_result  (w_result)
  );

  always_comb begin
    w_out        = r_bus.payload;
    w_out.result = w_result;
  end

  assign ms_to_ws_bus   = w_out;
  assign ms_to_ws_valid = r_ms_valid && w_ready_go && !ws_flush;

  assign MS_dest        = (r_ms_valid && r_bus.payload.gr_we) ? r_bus.payload.dest : 5'd0;
  assign MS_dest_data   = w_result;
  assign MS_inst_mfc0   = r_ms_valid && r_bus.payload.mfc0;
  assign ms_load_stall  = r_ms_valid && (r_bus.load_op != LOAD_OP_NONE) && !w_ready_go;
  assign MS_EX          = r_ms_valid && (w_has_ex || r_bus.payload.eret);

endmodule

// File: tb/tb_mem_stage.sv
// Scoreboard bench for mem_stage: directed scenarios plus randomized transactions checked
// against an arithmetic load model; a negedge monitor pops expected write-back buses.
module tb_mem_stage;
  import mem_stage_pkg::*;

  logic         clk = 1'b0;
  logic         reset;
  logic         ms_allowin;
  logic         es_to_ms_valid;
  logic [152:0] es_to_ms_bus;
  logic         ws_allowin;
  logic         ms_to_ws_valid;
  logic [116:0] ms_to_ws_bus;
  logic         data_sram_data_ok;
  logic [31:0]  data_sram_rdata;
  logic         ws_flush;
  logic [4:0]   MS_dest;
  logic [31:0]  MS_dest_data;
  logic         MS_inst_mfc0;
  logic         ms_load_stall;
  logic         MS_EX;

  mem_stage dut (
    .clk               (clk),
    .reset             (reset),
    .ms_allowin        (ms_allowin),
    .es_to_ms_valid    (es_to_ms_valid),
    .es_to_ms_bus      (es_to_ms_bus),
    .ws_allowin        (ws_allowin),
    .ms_to_ws_valid    (ms_to_ws_valid),
    .ms_to_ws_bus      (ms_to_ws_bus),
    .data_sram_data_ok (data_sram_data_ok),
    .data_sram_rdata   (data_sram_rdata),
    .ws_flush          (ws_flush),
    .MS_dest           (MS_dest),
    .MS_dest_data      (MS_dest_data),
    .MS_inst_mfc0      (MS_inst_mfc0),
    .ms_load_stall     (ms_load_stall),
    .MS_EX             (MS_EX)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  logic [116:0] exp_q[$];

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference: loads described as shifts/masks on whole words, not per-case bit slices.
  function automatic logic [31:0] ref_load(input int op, input logic [31:0] res,
                                           input logic [31:0] d, input logic [31:0] rt);
    int a;
    int k;
    int v;
    logic [63:0] m;
    a = int'(res & 32'd3);
    case (op)
      0: return d;
      1, 2: begin
        v = int'((d >> (8 * a)) & 32'hFF);
        if (op == 1 && v >= 128) v -= 256;
        return 32'(v);
      end
      3, 4: begin
        v = int'((d >> (16 * (a / 2))) & 32'hFFFF);
        if (op == 3 && v >= 32768) v -= 65536;
        return 32'(v);
      end
      5: begin
        k = 8 * (3 - a);
        m = (64'd1 << k) - 64'd1;
        return (d << k) | (rt & m[31:0]);
      end
      6: begin
        k = 8 * a;
        return (d >> k) | (rt & ~(32'hFFFF_FFFF >> k));
      end
      default: return res;
    endcase
  endfunction

  function automatic logic [116:0] mk_pl(input logic [4:0] ex, input logic eret, input logic gr_we,
                                         input logic [4:0] dest, input logic [31:0] result);
    logic [4:0]  rd;
    logic [31:0] badv;
    logic [31:0] pc;
    logic [2:0]  misc;
    logic        slot;
    rd   = 5'($urandom);
    badv = $urandom;
    pc   = $urandom;
    misc = 3'($urandom);
    slot = 1'($urandom);
    return {rd, misc, badv, ex, eret, slot, gr_we, dest, result, pc};
  endfunction

  function automatic logic [116:0] expect_bus(input logic [116:0] pl, input int op,
                                              input logic [31:0] d, input logic [31:0] rt);
    logic [116:0] e;
    e = pl;
    e[63:32] = ref_load(op, pl[63:32], d, rt);
    return e;
  endfunction

  always @(negedge clk) begin
    if (!reset && ms_to_ws_valid && ws_allowin) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL unexpected_output: got %h expected no transfer", ms_to_ws_bus);
      end else begin
        chk("ws_bus", ms_to_ws_bus, exp_q.pop_front());
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic latch(input logic [152:0] b);
    bit ok;
    ok = 1'b0;
    es_to_ms_valid = 1'b1;
    es_to_ms_bus   = b;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (ms_allowin) begin
        ok = 1'b1;
        break;
      end
    end
    chk("latch_allowin", ok, 1'b1);
    tick();
    es_to_ms_valid = 1'b0;
  endtask

  task automatic drain();
    for (int i = 0; i < 30 && exp_q.size() != 0; i++) begin
      ws_allowin = (i >= 3) ? 1'b1 : 1'($urandom_range(0, 1));
      tick();
    end
    ws_allowin = 1'b1;
    chk("drain_empty", 32'(exp_q.size()), 32'd0);
    exp_q.delete();
  endtask

  logic [116:0] pl;
  logic [31:0]  rt;
  logic [31:0]  d;
  int           op;
  int           kind;
  int           dly;
  int           stall_cnt;
  logic         req;
  logic [4:0]   ex;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1;
    es_to_ms_valid = 1'b0;
    es_to_ms_bus = '0;
    ws_allowin = 1'b1;
    data_sram_data_ok = 1'b0;
    data_sram_rdata = 32'd0;
    ws_flush = 1'b0;
    repeat (3) tick();
    reset = 1'b0;
    @(negedge clk);
    chk("rst_valid", ms_to_ws_valid, 1'b0);
    chk("rst_dest", MS_dest, 5'd0);
    chk("rst_stall", ms_load_stall, 1'b0);
    chk("rst_ex", MS_EX, 1'b0);
    chk("rst_allowin", ms_allowin, 1'b1);
    chk("rst_mfc0", MS_inst_mfc0, 1'b0);
    tick();

    // lb at byte 2, response one cycle late
    rt = $urandom;
    pl = mk_pl(NO_EX, 1'b0, 1'b1, 5'd3, 32'h1000_0002);
    data_sram_rdata = $urandom;
    latch({rt, 3'd1, 1'b1, pl});
    exp_q.push_back(expect_bus(pl, 1, 32'h1280_7F00, rt));
    stall_cnt = 0;
    @(negedge clk);
    if (ms_load_stall) stall_cnt++;
    tick();
    data_sram_data_ok = 1'b1;
    data_sram_rdata = 32'h1280_7F00;
    @(negedge clk);
    if (ms_load_stall) stall_cnt++;
    chk("lb_valid", ms_to_ws_valid, 1'b1);
    chk("lb_result", ms_to_ws_bus[63:32], 32'hFFFF_FF80);
    chk("lb_stall_cycles", 32'(stall_cnt), 32'd1);
    tick();
    data_sram_data_ok = 1'b0;
    drain();

    // lwl a=1 and lwr a=2
    for (int j = 0; j < 2; j++) begin
      pl = mk_pl(NO_EX, 1'b0, 1'b1, 5'd4, (j == 0) ? 32'h2000_0001 : 32'h2000_0002);
      latch({32'hAABB_CCDD, (j == 0) ? 3'd5 : 3'd6, 1'b1, pl});
      exp_q.push_back(expect_bus(pl, (j == 0) ? 5 : 6, 32'h1122_3344, 32'hAABB_CCDD));
      data_sram_data_ok = 1'b1;
      data_sram_rdata = 32'h1122_3344;
      @(negedge clk);
      chk("lwlr_valid", ms_to_ws_valid, 1'b1);
      chk(j == 0 ? "lwl_result" : "lwr_result", ms_to_ws_bus[63:32],
          (j == 0) ? 32'h3344_CCDD : 32'hAABB_1122);
      tick();
      data_sram_data_ok = 1'b0;
      drain();
    end

    // write-back stalled for 3 cycles, response arrives in the first
    ws_allowin = 1'b0;
    pl = mk_pl(NO_EX, 1'b0, 1'b1, 5'd5, 32'h3000_0000);
    latch({32'd0, 3'd0, 1'b1, pl});
    exp_q.push_back(expect_bus(pl, 0, 32'hCAFE_F00D, 32'd0));
    data_sram_data_ok = 1'b1;
    data_sram_rdata = 32'hCAFE_F00D;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      chk("buf_hold_allowin", ms_allowin, 1'b0);
      tick();
      data_sram_data_ok = 1'b0;
      data_sram_rdata = $urandom;
    end
    ws_allowin = 1'b1;
    @(negedge clk);
    chk("buf_release_valid", ms_to_ws_valid, 1'b1);
    chk("buf_release_data", ms_to_ws_bus[63:32], 32'hCAFE_F00D);
    tick();
    @(negedge clk);
    chk("buf_once", ms_to_ws_valid, 1'b0);
    tick();

    // flush while a lw waits; its late response must be dropped
    pl = mk_pl(NO_EX, 1'b0, 1'b1, 5'd6, 32'h4000_0000);
    latch({32'd0, 3'd0, 1'b1, pl});
    ws_flush = 1'b1;
    @(negedge clk);
    chk("flush_no_out", ms_to_ws_valid, 1'b0);
    tick();
    ws_flush = 1'b0;
    pl = mk_pl(NO_EX, 1'b0, 1'b1, 5'd7, 32'h4000_0010);
    latch({32'd0, 3'd0, 1'b1, pl});
    exp_q.push_back(expect_bus(pl, 0, 32'h0000_0042, 32'd0));
    data_sram_data_ok = 1'b1;
    data_sram_rdata = 32'hDEAD_BEEF;
    @(negedge clk);
    chk("stale_dropped", ms_to_ws_valid, 1'b0);
    chk("stale_stall", ms_load_stall, 1'b1);
    tick();
    data_sram_rdata = 32'h0000_0042;
    @(negedge clk);
    chk("after_cancel_valid", ms_to_ws_valid, 1'b1);
    chk("after_cancel_data", ms_to_ws_bus[63:32], 32'h0000_0042);
    tick();
    data_sram_data_ok = 1'b0;
    drain();

    // exception passes without waiting for data
    pl = mk_pl(5'h04, 1'b0, 1'b0, 5'd0, 32'h5000_0000);
    latch({32'd0, 3'd7, 1'b1, pl});
    exp_q.push_back(expect_bus(pl, 7, 32'd0, 32'd0));
    @(negedge clk);
    chk("exc_valid", ms_to_ws_valid, 1'b1);
    chk("exc_ms_ex", MS_EX, 1'b1);
    drain();

    // plain ALU op
    pl = mk_pl(NO_EX, 1'b0, 1'b1, 5'd8, 32'h0000_0005);
    latch({32'd0, 3'd7, 1'b0, pl});
    exp_q.push_back(expect_bus(pl, 7, 32'd0, 32'd0));
    @(negedge clk);
    chk("alu_dest", MS_dest, 5'd8);
    chk("alu_dest_data", MS_dest_data, 32'd5);
    chk("alu_stall", ms_load_stall, 1'b0);
    chk("alu_valid", ms_to_ws_valid, 1'b1);
    tick();
    @(negedge clk);
    chk("alu_gone_dest", MS_dest, 5'd0);
    chk("alu_gone_valid", ms_to_ws_valid, 1'b0);
    tick();

    // randomized mix
    for (int n = 0; n < 300; n++) begin
      kind = $urandom_range(0, 3);
      rt = $urandom;
      d = $urandom;
      ex = NO_EX;
      op = 7;
      req = 1'b1;
      case (kind)
        0: req = 1'b0;
        1: op = $urandom_range(0, 6);
        2: op = 7;
        default: begin
          ex = 5'($urandom_range(0, 30));
          req = 1'($urandom_range(0, 1));
        end
      endcase
      pl = mk_pl(ex, (kind == 3) ? 1'($urandom) : 1'b0, 1'($urandom), 5'($urandom), $urandom);
      ws_allowin = 1'($urandom_range(0, 1));
      data_sram_rdata = $urandom;
      latch({rt, 3'(op), req, pl});
      exp_q.push_back(expect_bus(pl, op, d, rt));
      if (req && ex == NO_EX) begin
        dly = $urandom_range(0, 3);
        for (int c = 0; c <= dly; c++) begin
          data_sram_data_ok = (c == dly);
          data_sram_rdata = (c == dly) ? d : $urandom;
          ws_allowin = 1'($urandom_range(0, 1));
          if (c == 0) begin
            @(negedge clk);
            chk("rnd_ms_ex", MS_EX, 1'b0);
          end
          tick();
        end
        data_sram_data_ok = 1'b0;
        data_sram_rdata = $urandom;
      end else begin
        @(negedge clk);
        chk("rnd_ms_ex", MS_EX, (ex != NO_EX) || pl[71]);
      end
      drain();
    end

    repeat (2) tick();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/mem_stage.md
Name: mem_stage

Overview:
- Memory-access stage of the 5-stage MIPS pipeline, between the execute stage and the write-back stage.
- Accepts the execute-to-memory bus and waits for the data-SRAM response of any load issued by the execute stage.
- Extracts and sign- or zero-extends load data, including merges for lwl and lwr.
- Forwards the result to write-back with a valid/allowin handshake.
- Provides forwarding, stall and exception information to decode and execute.
- Drops the response of any load that was in flight when a write-back flush occurs.

Parameters:
- ES_TO_MS_BUS_WD, 153: input bus width (`ES_TO_MS_BUS_WD in mycpu.h).
- MS_TO_WS_BUS_WD, 117: output bus width (`MS_TO_WS_BUS_WD in mycpu.h).

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- ms_allowin  out  1  stage can accept new data
- es_to_ms_valid  in  1  execute stage data valid
- es_to_ms_bus  in  153  {rt_value[152:121], load_op[120:118], data_req[117], payload[116:0]}; payload uses the output bus layout, result field = ALU result or load address
- ws_allowin  in  1  write-back can accept
- ms_to_ws_valid  out  1  output valid
- ms_to_ws_bus  out  117  {rd 116:112, mfc0 111, mtc0 110, pc_error 109, BadVAddr 108:77, ex_code 76:72, eret 71, slot 70, gr_we 69, dest 68:64, result 63:32, pc 31:0}
- data_sram_data_ok  in  1  one-cycle pulse: read/write response returned
- data_sram_rdata  in  32  read data, valid with data_ok
- ws_flush  in  1  write-back exception or eret this cycle
- MS_dest  out  5  destination register for dependency check, 0 when invalid or gr_we=0
- MS_dest_data  out  32  forwarded result
- MS_inst_mfc0  out  1  valid mfc0 in this stage
- ms_load_stall  out  1  valid load whose data has not yet returned (decode must stall)
- MS_EX  out  1  valid instruction with ex_code != `NO_EX or eret (execute stage suppresses stores)

Behaviour:
- Registers: ms_valid, bus_r, rdata_buf[31:0], rdata_buf_valid, cancel_cnt[1:0].
- Reset values: all registers 0. Consequently ms_to_ws_valid=0, MS_dest=0, ms_load_stall=0, MS_EX=0.
- `NO_EX is 5'h1f. The ex_code field of bus_r resets to 5'h1f.
- Handshake:
  - ms_allowin = !ms_valid || (ms_ready_go && ws_allowin).
  - A new bus is latched when es_to_ms_valid && ms_allowin.
  - ms_valid <= es_to_ms_valid whenever ms_allowin.
- Outstanding request: an instruction with data_req=1 has an SRAM request already accepted by the data SRAM. At most one such request exists per stage.
- ms_ready_go:
  - 1 if data_req=0 or ex_code != `NO_EX.
  - Otherwise 1 when cancel_cnt==0 and (data_ok || rdata_buf_valid).
- Data buffering:
  - If data_ok arrives with cancel_cnt==0 while ws_allowin=0, capture rdata_buf and set rdata_buf_valid.
  - Clear rdata_buf_valid when the instruction leaves the stage.
  - Selected data = rdata_buf_valid ? rdata_buf : data_sram_rdata.
- Load extraction, with a = result[1:0], d = selected data, rt = rt_value:
  - load_op 0 lw: d.
  - load_op 1 lb / 2 lbu: byte a, sign- or zero-extended.
  - load_op 3 lh / 4 lhu: halfword a[1], sign- or zero-extended.
  - load_op 5 lwl: a=0 {d[7:0],rt[23:0]}; a=1 {d[15:0],rt[15:0]}; a=2 {d[23:0],rt[7:0]}; a=3 d.
  - load_op 6 lwr: a=0 d; a=1 {rt[31:24],d[31:8]}; a=2 {rt[31:16],d[31:16]}; a=3 {rt[31:8],d[31:24]}.
  - load_op 7: no load; result passes unchanged. Stores use load_op=7 with data_req=1, and data_ok only completes them.
- Output: ms_to_ws_bus = payload with result replaced by the extraction result. ms_to_ws_valid = ms_valid && ms_ready_go && !ws_flush.
- Flush (ws_flush=1):
  - Next cycle ms_valid=0 and rdata_buf_valid=0.
  - If the stage holds a valid data_req instruction whose data_ok has not yet been seen (in this cycle or earlier), cancel_cnt increments.
  - A simultaneous data_ok in the flush cycle counts as seen, so no increment.
- cancel_cnt: decrements on each data_ok while >0, and that data_ok is dropped. A latch of a new instruction is still allowed while cancel_cnt>0.
- Stall output: ms_load_stall = ms_valid && load_op<7 && !ms_ready_go.
- Forwarding outputs: MS_dest_data = extraction result; MS_dest = dest when ms_valid && gr_we, else 0.
- Exceptions: an instruction carrying an exception passes through without waiting for data. It is flushed when it reaches write-back.
- Reset mid-operation: reset clears cancel_cnt. The SRAM is reset together with the core, so no stale data_ok is expected.

Decomposition:
- mycpu.h holds the constants:
  - `ES_TO_MS_BUS_WD, `MS_TO_WS_BUS_WD, `NO_EX.
  - LOAD_OP_* encodings 0..7.
- One sub-module, load_align: combinational extraction of (load_op, addr[1:0], data, rt_value) into a 32-bit result. It is unit-tested separately.

Test Plan:
- lb with addr low=2, data_ok the cycle after latch, rdata=32'h1280_7F00 -> result 32'hFFFF_FF80, ms_load_stall=1 for exactly one cycle.
- lwl with a=1, rt=32'hAABB_CCDD, rdata=32'h1122_3344 -> result 32'h3344_CCDD; lwr with a=2 and the same inputs -> 32'hAABB_1122.
- ws_allowin held 0 for 3 cycles, data_ok in the first cycle -> rdata_buf captures the data; on release ms_to_ws_valid=1 once with the correct data, and ms_allowin stays 0 until then.
- ws_flush while a lw is waiting -> ms_valid=0 and cancel_cnt=1. The next lw latches; the first data_ok (stale 32'hDEAD_BEEF) is dropped; the second data_ok (32'h0000_0042) yields result 32'h42.
- Instruction with ex_code=5'h04 and data_req=1 -> ms_to_ws_valid the cycle after latch with no data_ok needed, MS_EX=1.
- Non-memory ALU op, result 32'h5, dest 8, gr_we 1 -> MS_dest=8, MS_dest_data=5, one-cycle pass-through with ms_load_stall=0.
